// File: rtl/sd_spi_responder.sv
// SPI-mode SD card command responder: parses 6-byte command frames and answers R1 (plus OCR for CMD58).
// Define SD_RESP_CRC_EN to check the CRC7 of each frame; otherwise the CRC byte is ignored.
module sd_spi_responder (
    input  logic        CLOCK50,
    input  logic        RESET,
    input  logic        SCLK,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO,
    output logic        CMD_STB,
    output logic [5:0]  CMD_IDX,
    output logic [31:0] CMD_ARG,
    output logic        IN_IDLE
);

    // state   | meaning
    // HUNT    | waiting for a byte starting with 01 (command start)
    // CMD     | collecting 4 argument bytes then the CRC byte
    // GAP     | one 0xFF byte on MISO before the response
    // RESP    | R1 byte on MISO
    // PAYLOAD | 4 OCR bytes on MISO (CMD58 only)
    typedef enum logic [2:0] {HUNT, CMD, GAP, RESP, PAYLOAD} state_t;

    state_t      state, state_nxt;
    logic [1:0]  sclk_sync, cs_sync, mosi_sync;
    logic        sclk_prev;
    logic        sclk_rise, sclk_fall, cs_high, mosi_bit;
    logic [2:0]  bit_cnt, byte_cnt;
    logic [7:0]  rx_sr, rx_byte, tx_sr, tx_load, r1_q, r1_new;
    logic        byte_done, frame_done;
    logic [5:0]  idx_q;
    logic [31:0] arg_sr;
    logic        app_flag, is_cmd58;
    logic        idle_new, app_new, illegal, crc_ok, miso_q;

    always_ff @(posedge CLOCK50) begin
        if (RESET) begin
            sclk_sync <= 2'b00;
            cs_sync   <= 2'b11;
            mosi_sync <= 2'b11;
            sclk_prev <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], SCLK};
            cs_sync   <= {cs_sync[0], CS};
            mosi_sync <= {mosi_sync[0], MOSI};
            sclk_prev <= sclk_sync[1];
        end
    end

    assign sclk_rise = sclk_sync[1] & ~sclk_prev;
    assign sclk_fall = ~sclk_sync[1] & sclk_prev;
    assign cs_high   = cs_sync[1];
    assign mosi_bit  = mosi_sync[1];
    assign rx_byte   = {rx_sr[6:0], mosi_bit};
    assign byte_done = sclk_rise & ~cs_high & (bit_cnt == 3'd7);

    always_ff @(posedge CLOCK50) begin
        if (RESET || cs_high) begin
            bit_cnt <= 3'd0;
        end else if (sclk_rise) begin
            bit_cnt <= bit_cnt + 3'd1;
        end
        if (RESET) begin
            rx_sr <= 8'h00;
        end else if (sclk_rise) begin
            rx_sr <= rx_byte;
        end
    end

    always_ff @(posedge CLOCK50) begin
        if (RESET) begin
            state <= HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    // CS high overrides everything, including a CRC byte completing in the same cycle
    always_comb begin
        state_nxt  = state;
        frame_done = 1'b0;
        tx_load    = 8'hFF;
        if (cs_high) begin
            state_nxt = HUNT;
        end else if (byte_done) begin
            case (state)
                HUNT: begin
                    if (rx_byte[7:6] == 2'b01) state_nxt = CMD;
                end
                CMD: begin
                    if (byte_cnt == 3'd4) begin
                        state_nxt  = GAP;
                        frame_done = 1'b1;
                    end
                end
                GAP: begin
                    state_nxt = RESP;
                    tx_load   = r1_q;
                end
                RESP: begin
                    if (is_cmd58) begin
                        state_nxt = PAYLOAD;
                        tx_load   = 8'h00;
                    end else begin
                        state_nxt = HUNT;
                    end
                end
                PAYLOAD: begin
                    case (byte_cnt)
                        3'd0:    tx_load = 8'hFF;
                        3'd1:    tx_load = 8'h80;
                        3'd2:    tx_load = 8'h00;
                        default: tx_load = 8'hFF;
                    endcase
                    if (byte_cnt == 3'd3) state_nxt = HUNT;
                end
                default: state_nxt = HUNT;
            endcase
        end
    end

    always_ff @(posedge CLOCK50) begin
        if (RESET || cs_high || (state_nxt != state)) begin
            byte_cnt <= 3'd0;
        end else if (byte_done) begin
            byte_cnt <= byte_cnt + 3'd1;
        end
    end

`ifdef SD_RESP_CRC_EN
    function automatic logic [6:0] crc7_calc(input logic [39:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
        end
        return crc;
    endfunction

    assign crc_ok = (crc7_calc({2'b01, idx_q, arg_sr}) == rx_byte[7:1]);
`else
    assign crc_ok = 1'b1;
`endif

    always_comb begin
        idle_new = IN_IDLE;
        app_new  = 1'b0;
        illegal  = 1'b0;
        case (idx_q)
            6'd0:  idle_new = 1'b1;
            6'd55: app_new  = 1'b1;
            6'd41: begin
                if (app_flag) idle_new = 1'b0;
                else          illegal  = 1'b1;
            end
            6'd58: ;
            default: illegal = 1'b1;
        endcase
        // A corrupted frame is reported but not executed
        if (!crc_ok) begin
            idle_new = IN_IDLE;
            app_new  = app_flag;
        end
        r1_new = {4'b0000, ~crc_ok, illegal, 1'b0, idle_new};
    end

    always_ff @(posedge CLOCK50) begin
        if (RESET) begin
            idx_q    <= 6'd0;
            arg_sr   <= 32'd0;
            CMD_STB  <= 1'b0;
            CMD_IDX  <= 6'd0;
            CMD_ARG  <= 32'd0;
            IN_IDLE  <= 1'b1;
            app_flag <= 1'b0;
            r1_q     <= 8'hFF;
            is_cmd58 <= 1'b0;
        end else begin
            CMD_STB <= frame_done;
            if (state == HUNT && state_nxt == CMD) begin
                idx_q <= rx_byte[5:0];
            end
            if (state == CMD && byte_done && byte_cnt < 3'd4) begin
                arg_sr <= {arg_sr[23:0], rx_byte};
            end
            if (frame_done) begin
                CMD_IDX  <= idx_q;
                CMD_ARG  <= arg_sr;
                IN_IDLE  <= idle_new;
                app_flag <= app_new;
                r1_q     <= r1_new;
                is_cmd58 <= crc_ok && (idx_q == 6'd58);
            end
        end
    end

    always_ff @(posedge CLOCK50) begin
        if (RESET) begin
            tx_sr  <= 8'hFF;
            miso_q <= 1'b1;
        end else begin
            if (byte_done) begin
                tx_sr <= tx_load;
            end else if (sclk_fall) begin
                tx_sr <= {tx_sr[6:0], 1'b1};
            end
            if (cs_high || !(state == GAP || state == RESP || state == PAYLOAD)) begin
                miso_q <= 1'b1;
            end else if (sclk_fall) begin
                miso_q <= tx_sr[7];
            end
        end
    end

    assign MISO = miso_q;

endmodule

// File: tb/tb_sd_spi_responder.sv
// Bench for sd_spi_responder: bit-banged SPI host, scoreboard of expected MISO bytes and command strobes.
module tb_sd_spi_responder;
    localparam int HALF = 8;

    logic        CLOCK50 = 1'b0;
    logic        RESET   = 1'b1;
    logic        SCLK    = 1'b0;
    logic        CS      = 1'b1;
    logic        MOSI    = 1'b1;
    logic        MISO;
    logic        CMD_STB;
    logic [5:0]  CMD_IDX;
    logic [31:0] CMD_ARG;
    logic        IN_IDLE;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0]  exp_miso_q[$];
    logic [37:0] exp_stb_q[$];
    logic [37:0] obs_stb_q[$];
    logic        m_idle = 1'b1;
    logic        m_app  = 1'b0;

    sd_spi_responder dut (
        .CLOCK50 (CLOCK50),
        .RESET   (RESET),
        .SCLK    (SCLK),
        .CS      (CS),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .CMD_STB (CMD_STB),
        .CMD_IDX (CMD_IDX),
        .CMD_ARG (CMD_ARG),
        .IN_IDLE (IN_IDLE)
    );

    always #10 CLOCK50 = ~CLOCK50;

    always @(negedge CLOCK50) begin
        if (CMD_STB === 1'b1) obs_stb_q.push_back({CMD_IDX, CMD_ARG});
    end

`ifdef SD_RESP_CRC_EN
    function automatic logic [6:0] crc7_ref(input logic [39:0] d);
        logic [6:0] c;
        logic       fb;
        c = 7'd0;
        for (int i = 39; i >= 0; i--) begin
            fb = d[i] ^ c[6];
            c  = {c[5:0], 1'b0};
            if (fb) c = c ^ 7'h09;
        end
        return c;
    endfunction
`endif

    // One SPI mode-0 byte; MISO is sampled just before each rising edge
    task automatic xfer(input logic [7:0] tx);
        logic [7:0] rx;
        logic [7:0] exp;
        for (int i = 7; i >= 0; i--) begin
            MOSI = tx[i];
            repeat (HALF) @(negedge CLOCK50);
            rx[i] = MISO;
            SCLK  = 1'b1;
            repeat (HALF) @(negedge CLOCK50);
            SCLK  = 1'b0;
        end
        exp = (exp_miso_q.size() > 0) ? exp_miso_q.pop_front() : 8'hFF;
        tests_run++;
        if (rx !== exp) begin
            tests_failed++;
            $display("FAIL miso_byte (host sent %02h): got %02h expected %02h", tx, rx, exp);
        end
    endtask

    task automatic check_strobes();
        logic [37:0] e, o;
        repeat (4) @(negedge CLOCK50);
        while (exp_stb_q.size() > 0) begin
            e = exp_stb_q.pop_front();
            tests_run++;
            if (obs_stb_q.size() == 0) begin
                tests_failed++;
                $display("FAIL cmd_stb_missing: got none expected idx=%0d arg=%08h", e[37:32], e[31:0]);
            end else begin
                o = obs_stb_q.pop_front();
                if (o !== e) begin
                    tests_failed++;
                    $display("FAIL cmd_stb_value: got idx=%0d arg=%08h expected idx=%0d arg=%08h",
                             o[37:32], o[31:0], e[37:32], e[31:0]);
                end
            end
        end
        tests_run++;
        if (obs_stb_q.size() != 0) begin
            tests_failed++;
            $display("FAIL cmd_stb_extra: got %0d extra strobes expected 0", obs_stb_q.size());
            obs_stb_q.delete();
        end
    endtask

    task automatic model_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc,
                             output logic [7:0] r1, output logic ocr);
        logic crc_bad, illegal, idle_n, app_n;
        crc_bad = 1'b0;
`ifdef SD_RESP_CRC_EN
        crc_bad = (crc7_ref({2'b01, idx, arg}) != crc[7:1]);
`endif
        illegal = 1'b0;
        idle_n  = m_idle;
        app_n   = 1'b0;
        case (idx)
            6'd0:  idle_n = 1'b1;
            6'd55: app_n  = 1'b1;
            6'd41: if (m_app) idle_n = 1'b0; else illegal = 1'b1;
            6'd58: ;
            default: illegal = 1'b1;
        endcase
        if (crc_bad) begin
            idle_n = m_idle;
            app_n  = m_app;
        end
        r1     = {4'b0000, crc_bad, illegal, 1'b0, idle_n};
        ocr    = (idx == 6'd58) && !crc_bad;
        m_idle = idle_n;
        m_app  = app_n;
    endtask

    task automatic send_frame(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc,
                              input int ntrail, output logic [7:0] r1);
        logic       ocr;
        logic [7:0] rsp[$];
        model_cmd(idx, arg, crc, r1, ocr);
        rsp = {8'hFF, r1};
        if (ocr) begin
            rsp.push_back(8'h00); rsp.push_back(8'hFF); rsp.push_back(8'h80); rsp.push_back(8'h00);
        end
        repeat (6) exp_miso_q.push_back(8'hFF);
        for (int j = 0; j < ntrail; j++) exp_miso_q.push_back((j < rsp.size()) ? rsp[j] : 8'hFF);
        exp_stb_q.push_back({idx, arg});
        CS = 1'b0;
        xfer({2'b01, idx});
        xfer(arg[31:24]); xfer(arg[23:16]); xfer(arg[15:8]); xfer(arg[7:0]);
        xfer(crc);
        for (int j = 0; j < ntrail; j++) xfer(8'hFF);
        check_strobes();
        tests_run++;
        if (IN_IDLE !== m_idle) begin
            tests_failed++;
            $display("FAIL in_idle after cmd%0d: got %b expected %b", idx, IN_IDLE, m_idle);
        end
    endtask

    task automatic cs_pulse();
        CS = 1'b1;
        repeat (10) @(negedge CLOCK50);
        CS = 1'b0;
        repeat (4) @(negedge CLOCK50);
    endtask

    task automatic check_reset_values(input string tag);
        tests_run += 5;
        if (MISO !== 1'b1)     begin tests_failed++; $display("FAIL %s miso: got %b expected 1", tag, MISO); end
        if (CMD_STB !== 1'b0)  begin tests_failed++; $display("FAIL %s cmd_stb: got %b expected 0", tag, CMD_STB); end
        if (CMD_IDX !== 6'd0)  begin tests_failed++; $display("FAIL %s cmd_idx: got %0d expected 0", tag, CMD_IDX); end
        if (CMD_ARG !== 32'd0) begin tests_failed++; $display("FAIL %s cmd_arg: got %08h expected 0", tag, CMD_ARG); end
        if (IN_IDLE !== 1'b1)  begin tests_failed++; $display("FAIL %s in_idle: got %b expected 1", tag, IN_IDLE); end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        repeat (5) @(negedge CLOCK50);
        check_reset_values("reset");
        RESET = 1'b0;
        repeat (4) @(negedge CLOCK50);
    endtask

    task automatic test_cmd0();
        logic [7:0] r1;
        send_frame(6'd0, 32'h0, 8'h95, 2, r1);
        cs_pulse();
    endtask

    task automatic test_acmd41();
        logic [7:0] r1;
        send_frame(6'd55, 32'h0, 8'h65, 2, r1);
        send_frame(6'd41, 32'h4000_0000, 8'h77, 2, r1);
        tests_run++;
        if (IN_IDLE !== 1'b0) begin
            tests_failed++;
            $display("FAIL acmd41_idle_fall: got %b expected 0", IN_IDLE);
        end
        cs_pulse();
    endtask

    task automatic test_cmd58();
        logic [7:0] r1;
        send_frame(6'd58, 32'h0, 8'hFD, 6, r1);
        cs_pulse();
    endtask

    task automatic test_reset_midframe();
        CS = 1'b0;
        exp_miso_q.push_back(8'hFF);
        exp_miso_q.push_back(8'hFF);
        xfer(8'h40);
        xfer(8'h00);
        RESET = 1'b1;
        @(negedge CLOCK50);
        @(negedge CLOCK50);
        check_reset_values("reset_midframe");
        RESET  = 1'b0;
        m_idle = 1'b1;
        m_app  = 1'b0;
        check_strobes();
        cs_pulse();
    endtask

    task automatic test_cmd17();
        logic [7:0] r1;
        send_frame(6'd17, 32'h0000_0200, 8'h55, 2, r1);
        tests_run++;
        if (CMD_ARG !== 32'h0000_0200) begin
            tests_failed++;
            $display("FAIL cmd17_arg: got %08h expected 00000200", CMD_ARG);
        end
        cs_pulse();
    endtask

    task automatic test_abort();
        logic [7:0] r1;
        repeat (3) exp_miso_q.push_back(8'hFF);
        xfer(8'h40); xfer(8'h00); xfer(8'h00);
        cs_pulse();
        check_strobes();
        send_frame(6'd8, 32'h0000_01AA, 8'h87, 2, r1);
        tests_run++;
        if (CMD_IDX !== 6'd8) begin
            tests_failed++;
            $display("FAIL abort_then_cmd8_idx: got %0d expected 8", CMD_IDX);
        end
        cs_pulse();
    endtask

    // CS rises on the same host edge as the last CRC bit: frame must be dropped
    task automatic test_abort_crc_edge();
        logic [7:0] r1;
        logic [7:0] crc;
        crc = 8'h95;
        repeat (5) exp_miso_q.push_back(8'hFF);
        xfer(8'h40); xfer(8'h00); xfer(8'h00); xfer(8'h00); xfer(8'h00);
        for (int i = 7; i >= 1; i--) begin
            MOSI = crc[i];
            repeat (HALF) @(negedge CLOCK50);
            SCLK = 1'b1;
            repeat (HALF) @(negedge CLOCK50);
            SCLK = 1'b0;
        end
        MOSI = crc[0];
        repeat (HALF) @(negedge CLOCK50);
        SCLK = 1'b1;
        CS   = 1'b1;
        repeat (HALF) @(negedge CLOCK50);
        SCLK = 1'b0;
        check_strobes();
        cs_pulse();
        send_frame(6'd0, 32'h0, 8'h95, 2, r1);
        cs_pulse();
    endtask

    task automatic test_back_to_back();
        logic [7:0] r1;
        send_frame(6'd55, 32'h0, 8'h65, 2, r1);
        send_frame(6'd8, 32'h0000_01AA, 8'h87, 2, r1);
        send_frame(6'd41, 32'h4000_0000, 8'h77, 2, r1);
        tests_run++;
        if (r1 !== 8'h05 || IN_IDLE !== 1'b1) begin
            tests_failed++;
            $display("FAIL app_flag_cleared: got r1=%02h idle=%b expected r1=05 idle=1", r1, IN_IDLE);
        end
        cs_pulse();
    endtask

`ifdef SD_RESP_CRC_EN
    task automatic test_crc_error();
        logic [7:0] r1;
        send_frame(6'd0, 32'h0, 8'h01, 2, r1);
        cs_pulse();
    endtask
`endif

    initial begin
        test_reset();
        test_cmd0();
        test_acmd41();
        test_cmd58();
        test_reset_midframe();
        test_cmd17();
        test_abort();
        test_abort_crc_edge();
        test_back_to_back();
`ifdef SD_RESP_CRC_EN
        test_crc_error();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

endmodule
